if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch front end of the pipelined CPU. Sits directly upstream of the decode stage.
//  Owns the PC and issues in-order requests to instruction memory over a valid/ready handshake.
//  Buffers returned words in a small FIFO and presents {pc, instr, pc+4} to decode with valid/ready.
//  Handles branch/jump redirects from EX by flushing the FIFO and discarding in-flight responses.
// PARAMETERS
//  XLEN      32            address/instruction width
//  RESET_PC  32'h0000_0000 PC value loaded on reset
//  DEPTH     2             FIFO entries, and also the max outstanding requests (credit limit); power of 2, >=2
// PORTS
//  clk             in   1     rising-edge clock, single clock domain
//  reset           in   1     asynchronous, active-low reset (0 = reset asserted)
//  redirect_valid  in   1     EX resolved a taken branch/jump this cycle
//  redirect_pc     in   XLEN  target PC; must be word-aligned
//  imem_req_valid  out  1     fetch request valid
//  imem_req_addr   out  XLEN  fetch address (= pc_q)
//  imem_req_ready  in   1     memory accepts the request
//  imem_rsp_valid  in   1     instruction word returned; in order, latency >=1 cycle
//  imem_rsp_data   in   XLEN  instruction word
//  id_valid        out  1     entry available to decode
//  id_instr        out  XLEN  instruction at FIFO head
//  id_pc           out  XLEN  PC of that instruction
//  id_pc_plus4     out  XLEN  id_pc + 4, modulo 2^XLEN
//  id_ready        in   1     decode consumes the head entry (no stall)
// BEHAVIOUR
//  - Reset (reset==0, async): pc_q=RESET_PC, FIFO empty, outstanding=0, drop=0, state=BOOT.
//    All outputs are 0 except imem_req_addr, which is RESET_PC.
//  - States:
//    - BOOT: one cycle after reset deasserts; imem_req_valid=0. Always goes to RUN.
//    - RUN: normal fetching.
//    - FLUSH: stale responses are still in flight after a redirect.
//  - RUN: imem_req_valid=1 iff (outstanding + fifo_count) < DEPTH (credit rule; the FIFO never overflows).
//  - Request handshake fires when imem_req_valid && imem_req_ready.
//    On fire: pc_q += 4 (wraps modulo 2^XLEN), outstanding++.
//  - Each imem_rsp_valid decrements outstanding (or drop, in FLUSH).
//    In RUN the word is pushed with the PC tag taken from a tag FIFO written at request time.
//  - id_valid = FIFO non-empty.
//    id_valid && id_ready pops the head. The head is stable while id_valid && !id_ready.
//  - Push and pop in the same cycle are both performed; count is unchanged.
//  - Bypass: none. Minimum latency is request accepted at cycle N, response at N+L, id_valid at N+L+1.
//  - redirect_valid (any state, highest priority):
//    - pc_q=redirect_pc; FIFO and tag FIFO cleared; id_valid=0 next cycle.
//    - drop = outstanding, minus 1 if a response arrives that same cycle.
//    - A request firing in the redirect cycle is counted into drop, not outstanding.
//    - outstanding=0. Next state is FLUSH if the new drop>0, else RUN.
//    - A pop in the redirect cycle is allowed; decode is responsible for squashing it.
//  - FLUSH: imem_req_valid=0. Each response decrements drop and is discarded (never pushed).
//    When drop reaches 0, go to RUN next cycle.
//    A second redirect during FLUSH reloads pc_q; drop is kept, since no new requests were issued.
//  - imem_rsp_valid with outstanding==0 and drop==0 is a protocol error. It is ignored, and asserted in simulation.
//  - Counters are $clog2(DEPTH)+1 bits wide; they never exceed DEPTH.
// STRUCTURE
//  - Shared package cpu_pkg holds: XLEN, RESET_PC, the fetch-state enum {BOOT,RUN,FLUSH}, and NOP encoding 32'h0.
//  - One sub-module: fetch_fifo (DEPTH x 2*XLEN synchronous FIFO).
//    It provides a flush input, and push/pop/full/empty/count signals.
//    One instance stores {pc, instr}; the PC tag queue lives in the same module via a separate write pointer.
//  - Top level contains the PC register, the credit/drop counters and the FSM.
// TESTING
//  1. Reset and stream, mem latency 1, id_ready=1:
//     - Release reset; requests issue at 0,4,8,... from the 2nd cycle.
//     - id_pc sequence 0,4,8 with matching instr.
//     - id_pc_plus4 = id_pc+4.
//  2. Backpressure, id_ready=0 for 6 cycles:
//     - Exactly DEPTH=2 requests are accepted, then imem_req_valid=0.
//     - Head holds pc=0; after release, 0,4,8 arrive with no loss or duplication.
//  3. Redirect with 2 in flight, latency 3:
//     - redirect_pc=0x100. The next 2 responses are dropped (state FLUSH).
//     - The first id_pc after that is 0x100.
//  4. Redirect coincident with response and request fire:
//     - drop is computed correctly; no stale instruction reaches decode.
//     - 0x200 is the next id_pc.
//  5. Async reset mid-operation:
//     - Pull reset low between clock edges while the FIFO is full.
//     - id_valid=0 and imem_req_valid=0 immediately; pc restarts at RESET_PC.
//  6. PC wrap:
//     - redirect_pc=32'hFFFF_FFFC; the following fetch address is 0x0.
//     - id_pc_plus4=0x0 for that entry.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch front end.
//   XLEN     : architectural address / instruction width
//   RESET_PC : PC loaded while reset is asserted
//   NOP      : instruction word presented to decode when nothing is valid
//   fetch_state_e : fetch sequencer states (BOOT, RUN, FLUSH)
package cpu_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH entries of {pc, instr}, plus a PC tag queue.
// The tag queue is written when a fetch request is accepted and read when
// the matching response is pushed, so each stored word carries its own PC.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   flush         : clears both queues (takes priority over push/pop)
//   tag_push      : record tag_pc for a request accepted this cycle
//   tag_pc        : PC of that request
//   push          : store push_instr with the oldest tag
//   push_instr    : returned instruction word
//   pop           : drop the head entry
//   full, empty   : entry-queue status
//   count         : number of stored entries
//   head_pc/instr : head entry fields
module fetch_fifo #(
    parameter int  XLEN  = 32,
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            tag_push,
    input  logic [XLEN-1:0] tag_pc,
    input  logic            push,
    input  logic [XLEN-1:0] push_instr,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr
);

    logic [2*XLEN-1:0] mem     [DEPTH];
    logic [XLEN-1:0]   tag_mem [DEPTH];
    logic [AW-1:0]     wp, rp, tag_wp, tag_rp;
    logic [CW-1:0]     cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp     <= '0;
            rp     <= '0;
            tag_wp <= '0;
            tag_rp <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wp     <= '0;
            rp     <= '0;
            tag_wp <= '0;
            tag_rp <= '0;
            cnt    <= '0;
        end else begin
            if (tag_push) tag_wp <= tag_wp + AW'(1);
            if (push) begin
                wp     <= wp + AW'(1);
                tag_rp <= tag_rp + AW'(1);
            end
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; contents are only observed through the head
    // when the queue is non-empty.
    always_ff @(posedge clk) begin
        if (tag_push && !flush) tag_mem[tag_wp] <= tag_pc;
        if (push && !flush)     mem[wp]         <= {tag_mem[tag_rp], push_instr};
    end

    assign count      = cnt;
    assign full       = (cnt == CW'(DEPTH));
    assign empty      = (cnt == '0);
    assign head_pc    = mem[rp][2*XLEN-1:XLEN];
    assign head_instr = mem[rp][XLEN-1:0];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end. Owns the PC, issues in-order requests to
// instruction memory under a credit limit of DEPTH, buffers responses and
// presents {pc, instr, pc+4} to decode. Redirects from EX flush the buffer
// and discard responses to requests that were already in flight.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   redirect_valid/pc   : taken branch/jump target from EX
//   imem_req_valid/addr : fetch request to instruction memory
//   imem_req_ready      : memory accepts the request
//   imem_rsp_valid/data : in-order instruction word returned
//   id_valid            : head entry available to decode
//   id_instr/pc/pc_plus4: head entry contents (zero when empty)
//   id_ready            : decode consumes the head entry
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    input  logic            id_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic [XLEN-1:0] head_pc, head_instr;
    logic            req_fire, rsp_ok, rsp_push, pop;

    // Credit covers both in-flight requests and buffered words, so a
    // response always finds a free FIFO slot.
    assign imem_req_valid = (state_q == RUN) &&
                            ((outstanding_q + fifo_count) < CW'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing owed is a protocol error and is ignored.
    assign rsp_ok   = imem_rsp_valid && ((outstanding_q != '0) || (drop_q != '0));
    assign rsp_push = rsp_ok && (state_q == RUN) && (outstanding_q != '0) &&
                      !redirect_valid;
    assign pop      = id_ready && !fifo_empty;

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect_valid) begin
            // Everything owed by memory becomes stale: live requests, any
            // already being dropped, and one firing right now. A response
            // landing this cycle settles one of them.
            drop_d        = outstanding_q + drop_q + CW'(req_fire) - CW'(rsp_ok);
            outstanding_d = '0;
            state_d       = (drop_d != '0) ? FLUSH : RUN;
        end else begin
            case (state_q)
                BOOT:  state_d = RUN;
                RUN:   outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
                FLUSH: begin
                    drop_d = drop_q - CW'(rsp_ok);
                    if (drop_d == '0) state_d = RUN;
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            if (redirect_valid) pc_q <= redirect_pc;
            else if (req_fire)  pc_q <= pc_q + XLEN'(4);
        end
    end

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .flush      (redirect_valid),
        .tag_push   (req_fire),
        .tag_pc     (pc_q),
        .push       (rsp_push),
        .push_instr (imem_rsp_data),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    assign id_valid    = !fifo_empty;
    assign id_instr    = fifo_empty ? XLEN'(NOP) : head_instr;
    assign id_pc       = fifo_empty ? '0 : head_pc;
    assign id_pc_plus4 = fifo_empty ? '0 : head_pc + XLEN'(4);

    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rsp_valid && (outstanding_q == '0) && (drop_q == '0)));

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_push && fifo_full && !pop));

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_ready;

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: what decode must see and what memory owes.
    logic [31:0] fetch_pc, exp_pc, hold_pc;
    logic        hold_v;
    int          live;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;
    int          last_due = 0;
    logic [31:0] popped[$];
    logic [31:0] popped_p4[$];
    logic [31:0] fired[$];
    int          fires, pops;

    // Stimulus controls.
    logic        ctl_ready, ctl_redir, ctl_coinc, coinc_hit;
    logic [31:0] ctl_redir_pc;
    logic        rnd_mode;
    int          lat;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // which: 0 = popped pc, 1 = popped pc_plus4, 2 = fired request address
    task automatic chk_q(input string name, input int which, input int idx, input logic [31:0] exp);
        int n;
        logic [31:0] v;
        case (which)
            0:       n = popped.size();
            1:       n = popped_p4.size();
            default: n = fired.size();
        endcase
        if (idx >= n) begin
            checks++;
            errors++;
            $display("FAIL %s: only %0d entries recorded, required entry %0d = %h", name, n, idx, exp);
        end else begin
            case (which)
                0:       v = popped[idx];
                1:       v = popped_p4[idx];
                default: v = fired[idx];
            endcase
            chk(name, v, exp);
        end
    endtask

    task automatic model_reset();
        fetch_pc = 32'h0;
        exp_pc   = 32'h0;
        live     = 0;
        hold_v   = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        popped.delete();
        popped_p4.delete();
        fired.delete();
    endtask

    // Called at a falling edge: check outputs, choose inputs for the next
    // rising edge, advance the model by that edge, then wait a cycle.
    task automatic cycle();
        logic fire, pop, rsp, redir, rdy, rrdy;
        logic [31:0] rpc;
        int due;
        if (hold_v) begin
            chk("head_hold_valid", id_valid, 1'b1);
            chk("head_hold_pc", id_pc, hold_pc);
        end
        if (id_valid) begin
            chk("pc_plus4", id_pc_plus4, id_pc + 32'd4);
            chk("instr_tag", id_instr, instr_of(id_pc));
        end
        if (imem_req_valid) begin
            chk("fetch_addr", imem_req_addr, fetch_pc);
            chk("credit", live < DEPTH, 1'b1);
        end

        rdy  = rnd_mode ? ($urandom_range(3) != 0) : ctl_ready;
        rrdy = rnd_mode ? ($urandom_range(2) != 0) : 1'b1;
        rsp  = (mq_due.size() > 0) && (mq_due[0] <= cyc);
        fire = imem_req_valid && rrdy;
        pop  = id_valid && rdy;
        redir = ctl_redir;
        rpc   = ctl_redir_pc;
        if (ctl_coinc && fire && rsp) begin
            redir     = 1'b1;
            coinc_hit = 1'b1;
            ctl_coinc = 1'b0;
        end
        if (rnd_mode && ($urandom_range(29) == 0)) begin
            redir = 1'b1;
            rpc   = $urandom & 32'hFFFF_FFFC;
        end
        ctl_redir = 1'b0;

        id_ready       = rdy;
        imem_req_ready = rrdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instr_of(mq_addr[0]) : $urandom;

        if (pop) begin
            chk("stream_pc", id_pc, exp_pc);
            popped.push_back(id_pc);
            popped_p4.push_back(id_pc_plus4);
            exp_pc = exp_pc + 32'd4;
            live--;
            pops++;
        end
        if (rsp) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (fire) begin
            due = cyc + (rnd_mode ? int'($urandom_range(4, 1)) : lat);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(due);
            fired.push_back(imem_req_addr);
            fires++;
        end
        hold_v  = id_valid && !rdy && !redir;
        hold_pc = id_pc;
        if (redir) begin
            exp_pc   = rpc;
            fetch_pc = rpc;
            live     = 0;
            popped.delete();
            popped_p4.delete();
            fired.delete();
        end else if (fire) begin
            fetch_pc = fetch_pc + 32'd4;
            live++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive_idle();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        id_ready       = 1'b0;
    endtask

    // Entered at a falling edge; leaves at a falling edge in BOOT.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        drive_idle();
        ctl_ready = 1'b1;
        ctl_redir = 1'b0;
        ctl_coinc = 1'b0;
        coinc_hit = 1'b0;
        ctl_redir_pc = 32'h0;
        rnd_mode  = 1'b0;
        lat       = 1;
        fires     = 0;
        pops      = 0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);

        // 1: stream, latency 1
        reset = 1'b1;
        cycle();
        chk("t1_first_req_valid", imem_req_valid, 1'b1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0);
        repeat (12) cycle();
        chk_q("t1_pc0", 0, 0, 32'h0);
        chk_q("t1_pc1", 0, 1, 32'h4);
        chk_q("t1_pc2", 0, 2, 32'h8);
        chk_q("t1_pc0_plus4", 1, 0, 32'h4);

        // 2: backpressure
        do_reset();
        ctl_ready = 1'b0;
        fires = 0;
        repeat (6) cycle();
        chk("t2_accepted", fires, DEPTH);
        chk("t2_req_stalled", imem_req_valid, 1'b0);
        chk("t2_head_valid", id_valid, 1'b1);
        chk("t2_head_pc", id_pc, 32'h0);
        ctl_ready = 1'b1;
        repeat (12) cycle();
        chk_q("t2_pc0", 0, 0, 32'h0);
        chk_q("t2_pc1", 0, 1, 32'h4);
        chk_q("t2_pc2", 0, 2, 32'h8);

        // 3: redirect with two requests in flight, latency 3
        do_reset();
        lat = 3;
        repeat (3) cycle();
        chk("t3_two_in_flight", imem_req_valid, 1'b0);
        ctl_redir    = 1'b1;
        ctl_redir_pc = 32'h100;
        repeat (16) cycle();
        chk_q("t3_pc0", 0, 0, 32'h100);
        chk_q("t3_pc1", 0, 1, 32'h104);

        // 4: redirect in the same cycle as a response and a request fire
        do_reset();
        lat = 1;
        coinc_hit    = 1'b0;
        ctl_coinc    = 1'b1;
        ctl_redir_pc = 32'h200;
        repeat (14) cycle();
        chk("t4_coincidence_seen", coinc_hit, 1'b1);
        chk_q("t4_pc0", 0, 0, 32'h200);
        chk_q("t4_pc1", 0, 1, 32'h204);

        // 5: asynchronous reset with the buffer full
        do_reset();
        ctl_ready = 1'b0;
        repeat (6) cycle();
        chk("t5_full_valid", id_valid, 1'b1);
        chk("t5_full_head", id_pc, 32'h0);
        #2;
        reset = 1'b0;
        drive_idle();
        #1;
        chk("t5_async_id_valid", id_valid, 1'b0);
        chk("t5_async_req_valid", imem_req_valid, 1'b0);
        chk("t5_async_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        model_reset();
        reset = 1'b1;
        ctl_ready = 1'b1;
        repeat (12) cycle();
        chk_q("t5_restart_req0", 2, 0, 32'h0);
        chk_q("t5_restart_pc0", 0, 0, 32'h0);

        // 6: PC wrap
        ctl_redir    = 1'b1;
        ctl_redir_pc = 32'hFFFF_FFFC;
        repeat (14) cycle();
        chk_q("t6_req0", 2, 0, 32'hFFFF_FFFC);
        chk_q("t6_req1", 2, 1, 32'h0);
        chk_q("t6_pc0", 0, 0, 32'hFFFF_FFFC);
        chk_q("t6_pc0_plus4", 1, 0, 32'h0);
        chk_q("t6_pc1", 0, 1, 32'h0);

        // Randomized traffic: backpressure, memory stalls, variable latency,
        // redirects at arbitrary points.
        do_reset();
        rnd_mode = 1'b1;
        pops = 0;
        repeat (2000) cycle();
        rnd_mode = 1'b0;
        chk("rand_progress", pops > 150, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
